// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle RV32I sequencer.
// FETCH/DECODE/EXEC/MEM/WB with memory wait states; sticky trap on error.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic [3:0]  alu_control_en,
    output logic        imm_en,
    output logic        register_write_en,
    output logic [1:0]  rd_mux_en,
    output logic        instr_retired,
    output logic        illegal_instr,
    output logic        bus_error
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LIM[CW-1:0];
    localparam logic TO_ON = (TIMEOUT_CYCLES > 0);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       is_r;
    logic       is_i;
    logic       is_ld;
    logic       is_st;
    logic       legal;
    logic [3:0] dec_alu;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        dec_alu = 4'b0000;
        unique case (1'b1)
            opcode == OP_R: begin
                is_r = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 &&
                        (funct3 == 3'b000 || funct3 == 3'b101));
            end
            opcode == OP_I: begin
                unique case (funct3)
                    3'b001:  is_i = (funct7 == 7'b0000000);
                    3'b101:  is_i = (funct7 == 7'b0000000) ||
                                    (funct7 == 7'b0100000);
                    default: is_i = 1'b1;
                endcase
            end
            opcode == OP_LD: is_ld = (funct3 == 3'b010);
            opcode == OP_ST: is_st = (funct3 == 3'b010);
            default: ;
        endcase
        // funct7[5] only distinguishes sub/sra; for I-type only sra
        if (is_r) begin
            dec_alu = {funct7[5], funct3};
        end else if (is_i) begin
            dec_alu = {funct3 == 3'b101 && funct7[5], funct3};
        end
    end

    assign legal = is_r | is_i | is_ld | is_st;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          ready_now;
    logic          timeout;

    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    assign ready_now = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign timeout   = TO_ON && waiting && !ready_now &&
                       (wait_cnt == TO_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (timeout)         state_nx = S_TRAP;
                else if (imem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
            S_EXEC:   state_nx = (is_ld || is_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (timeout)         state_nx = S_TRAP;
                else if (dmem_ready) state_nx = is_ld ? S_WB : S_FETCH;
            end
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_FETCH;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (waiting && !ready_now && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_DECODE && !legal) illegal_instr <= 1'b1;
            if (timeout) bus_error <= 1'b1;
        end
    end

    // decoded controls are live from DECODE until the instruction ends
    logic active;
    assign active = reset && legal &&
                    (state == S_DECODE || state == S_EXEC ||
                     state == S_MEM || state == S_WB);

    assign imem_req          = reset && (state == S_FETCH);
    assign ir_en             = imem_req && imem_ready;
    assign dmem_req          = reset && (state == S_MEM);
    assign dmem_we           = dmem_req && is_st;
    assign register_write_en = reset && (state == S_WB);
    assign pc_en             = register_write_en ||
                               (dmem_req && is_st && dmem_ready);
    assign instr_retired     = pc_en;
    assign alu_control_en    = active ? dec_alu : 4'b0000;
    assign imm_en            = active && (is_i || is_ld || is_st);
    assign rd_mux_en         = {1'b0, active && is_ld};

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed table,
// randomized instructions against a decode/latency model, corner cases.
module tb_multicycle_control_unit;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_ILL = 3;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        ir_en;
    logic        pc_en;
    logic [3:0]  alu_control_en;
    logic        imm_en;
    logic        register_write_en;
    logic [1:0]  rd_mux_en;
    logic        instr_retired;
    logic        illegal_instr;
    logic        bus_error;

    multicycle_control_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk               (clk),
        .reset             (reset),
        .instr             (instr),
        .imem_req          (imem_req),
        .imem_ready        (imem_ready),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_ready        (dmem_ready),
        .ir_en             (ir_en),
        .pc_en             (pc_en),
        .alu_control_en    (alu_control_en),
        .imm_en            (imm_en),
        .register_write_en (register_write_en),
        .rd_mux_en         (rd_mux_en),
        .instr_retired     (instr_retired),
        .illegal_instr     (illegal_instr),
        .bus_error         (bus_error)
    );

    logic [15:0] allout;
    assign allout = {imem_req, dmem_req, dmem_we, ir_en, pc_en,
                     alu_control_en, imm_en, register_write_en,
                     rd_mux_en, instr_retired, illegal_instr, bus_error};

    int pass_cnt = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk({nm, " outputs zero in reset"}, int'(allout), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk({nm, " imem_req after release"}, int'(imem_req), 1);
    endtask

    // Reference decode written from the instruction-set rules
    function automatic void ref_decode(input logic [31:0] ins,
                                       output int kind,
                                       output logic [3:0] alu,
                                       output logic imm,
                                       output logic [1:0] rdm);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        kind = K_ILL;
        alu = 4'b0000;
        imm = 1'b0;
        rdm = 2'b00;
        if (op == 7'h33) begin
            kind = K_ALU;
            case ({f7, f3})
                {7'h00, 3'd0}: alu = 4'b0000;
                {7'h00, 3'd1}: alu = 4'b0001;
                {7'h00, 3'd2}: alu = 4'b0010;
                {7'h00, 3'd3}: alu = 4'b0011;
                {7'h00, 3'd4}: alu = 4'b0100;
                {7'h00, 3'd5}: alu = 4'b0101;
                {7'h00, 3'd6}: alu = 4'b0110;
                {7'h00, 3'd7}: alu = 4'b0111;
                {7'h20, 3'd0}: alu = 4'b1000;
                {7'h20, 3'd5}: alu = 4'b1101;
                default:       kind = K_ILL;
            endcase
        end else if (op == 7'h13) begin
            kind = K_ALU;
            imm = 1'b1;
            case (f3)
                3'd0: alu = 4'b0000;
                3'd1: if (f7 == 7'h00) alu = 4'b0001; else kind = K_ILL;
                3'd2: alu = 4'b0010;
                3'd3: alu = 4'b0011;
                3'd4: alu = 4'b0100;
                3'd5: begin
                    if (f7 == 7'h00)      alu = 4'b0101;
                    else if (f7 == 7'h20) alu = 4'b1101;
                    else                  kind = K_ILL;
                end
                3'd6: alu = 4'b0110;
                default: alu = 4'b0111;
            endcase
        end else if (op == 7'h03 && f3 == 3'd2) begin
            kind = K_LD;
            imm = 1'b1;
            rdm = 2'b01;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            kind = K_ST;
            imm = 1'b1;
        end
    endfunction

    function automatic int ref_latency(input int kind, input int fw,
                                       input int mw);
        case (kind)
            K_ALU:   return fw + 4;
            K_LD:    return fw + mw + 5;
            K_ST:    return fw + mw + 4;
            default: return fw + 3;
        endcase
    endfunction

    task automatic run_instr(input string nm, input logic [31:0] ins,
                             input int fw, input int mw, input int kind,
                             input logic [3:0] alu, input logic imm,
                             input logic [1:0] rdm, input int lat);
        int cyc = 0;
        int ic = 0;
        int dc = 0;
        int ie = 0;
        int rw = 0;
        int pc = 0;
        int rt = 0;
        int seen = 0;
        bit done = 0;
        bit bad_ctl = 0;
        bit bad_fctl = 0;
        bit bad_we = 0;
        bit bad_align = 0;
        bit quiet = 1;
        instr = ins;
        while (!done && cyc < 100) begin
            cyc++;
            imem_ready = imem_req ? (ic == fw) : 1'($urandom % 2);
            dmem_ready = dmem_req ? (dc == mw) : 1'($urandom % 2);
            #1;
            if (imem_req) begin
                ic++;
                if ({alu_control_en, imm_en, rd_mux_en} != 7'd0)
                    bad_fctl = 1;
            end else if (kind != K_ILL &&
                         {alu_control_en, imm_en, rd_mux_en} !=
                         {alu, imm, rdm}) begin
                bad_ctl = 1;
            end
            if (dmem_req) begin
                dc++;
                if (dmem_we != (kind == K_ST)) bad_we = 1;
            end
            if (ir_en) ie++;
            if (register_write_en) rw++;
            if (pc_en) pc++;
            if (kind != K_ST && pc_en != register_write_en) bad_align = 1;
            if (instr_retired) rt++;
            if (instr_retired || illegal_instr || bus_error) begin
                done = 1;
                seen = cyc;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, " latency"}, seen, lat);
        chk({nm, " retired"}, rt, (kind == K_ILL) ? 0 : 1);
        chk({nm, " reg write"}, rw,
            (kind == K_ALU || kind == K_LD) ? 1 : 0);
        chk({nm, " pc_en"}, pc, (kind == K_ILL) ? 0 : 1);
        chk({nm, " imem_req cycles"}, ic, fw + 1);
        chk({nm, " dmem_req cycles"}, dc,
            (kind == K_LD || kind == K_ST) ? mw + 1 : 0);
        chk({nm, " ir_en pulses"}, ie, 1);
        chk({nm, " controls held"}, int'(bad_ctl), 0);
        chk({nm, " controls zero in fetch"}, int'(bad_fctl), 0);
        chk({nm, " dmem_we"}, int'(bad_we), 0);
        chk({nm, " pc/rd same edge"}, int'(bad_align), 0);
        chk({nm, " illegal flag"}, int'(illegal_instr),
            (kind == K_ILL) ? 1 : 0);
        if (kind == K_ILL) begin
            repeat (4) begin
                imem_ready = 1'b1;
                dmem_ready = 1'b1;
                #1;
                if (allout != 16'h0002) quiet = 0;
                @(posedge clk);
                #1;
            end
            chk({nm, " trap quiet"}, int'(quiet), 1);
            do_reset({nm, " trap exit"});
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        int          fw;
        int          mw;
        int          kind;
        logic [3:0]  alu;
        logic        imm;
        logic [1:0]  rdm;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rw;
        int pc;
        int n;
        int got_mem;
        bit quiet;
        int kind;
        logic [3:0] alu;
        logic imm;
        logic [1:0] rdm;
        logic [31:0] ins;
        int fw;
        int mw;

        vecs[0]  = '{32'h002081B3, 0, 0,  K_ALU, 4'b0000, 1'b0, 2'b00, 4};
        vecs[1]  = '{32'h402081B3, 0, 0,  K_ALU, 4'b1000, 1'b0, 2'b00, 4};
        vecs[2]  = '{32'h40335293, 0, 0,  K_ALU, 4'b1101, 1'b1, 2'b00, 4};
        vecs[3]  = '{32'h00812203, 0, 3,  K_LD,  4'b0000, 1'b1, 2'b01, 8};
        vecs[4]  = '{32'h00512623, 0, 0,  K_ST,  4'b0000, 1'b1, 2'b00, 4};
        vecs[5]  = '{32'h00512623, 2, 2,  K_ST,  4'b0000, 1'b1, 2'b00, 8};
        vecs[6]  = '{32'h002081B3, 14, 0, K_ALU, 4'b0000, 1'b0, 2'b00, 18};
        vecs[7]  = '{32'h00500093, 1, 0,  K_ALU, 4'b0000, 1'b1, 2'b00, 5};
        vecs[8]  = '{32'h0020B1B3, 0, 0,  K_ALU, 4'b0011, 1'b0, 2'b00, 4};
        vecs[9]  = '{32'h00812203, 0, 14, K_LD,  4'b0000, 1'b1, 2'b01, 19};
        vecs[10] = '{32'hFFFFFFFF, 0, 0,  K_ILL, 4'b0000, 1'b0, 2'b00, 3};
        vecs[11] = '{32'h02009093, 2, 0,  K_ILL, 4'b0000, 1'b0, 2'b00, 5};

        instr = 32'h0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset = 1'b0;
        do_reset("power-on");

        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].fw,
                      vecs[i].mw, vecs[i].kind, vecs[i].alu, vecs[i].imm,
                      vecs[i].rdm, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            case ($urandom % 5)
                0: ins[6:0] = 7'b0110011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0000011;
                3: ins[6:0] = 7'b0100011;
                default: ;
            endcase
            case ($urandom % 3)
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
            if ($urandom % 4 != 0 &&
                (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011))
                ins[14:12] = 3'b010;
            fw = $urandom_range(0, 5);
            mw = $urandom_range(0, 5);
            ref_decode(ins, kind, alu, imm, rdm);
            run_instr($sformatf("rnd%0d %08h", i, ins), ins, fw, mw, kind,
                      alu, imm, rdm, ref_latency(kind, fw, mw));
        end

        // fetch timeout: ready never arrives
        n = 0;
        instr = 32'h002081B3;
        for (int c = 0; c < 40 && !bus_error; c++) begin
            imem_ready = 1'b0;
            dmem_ready = 1'($urandom % 2);
            #1;
            if (imem_req) n++;
            @(posedge clk);
            #1;
        end
        chk("fetch timeout bus_error", int'(bus_error), 1);
        chk("fetch timeout wait cycles", n, 15);
        quiet = 1;
        repeat (3) begin
            imem_ready = 1'b1;
            #1;
            if (allout != 16'h0001) quiet = 0;
            @(posedge clk);
            #1;
        end
        chk("bus trap quiet", int'(quiet), 1);
        do_reset("after fetch timeout");

        // data timeout on a load: no write-back, no PC update
        n = 0;
        rw = 0;
        pc = 0;
        instr = 32'h00812203;
        for (int c = 0; c < 60 && !bus_error; c++) begin
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) n++;
            if (register_write_en) rw++;
            if (pc_en) pc++;
            @(posedge clk);
            #1;
        end
        chk("mem timeout bus_error", int'(bus_error), 1);
        chk("mem timeout dmem_req cycles", n, 15);
        chk("mem timeout no reg write", rw + pc, 0);
        do_reset("after mem timeout");

        // reset asserted while a load waits in MEM
        got_mem = 0;
        rw = 0;
        pc = 0;
        for (int c = 0; c < 30 && got_mem < 2; c++) begin
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) got_mem++;
            if (register_write_en) rw++;
            if (pc_en) pc++;
            @(posedge clk);
            #1;
        end
        chk("mid-mem reached MEM", got_mem, 2);
        do_reset("mid-mem");
        chk("mid-mem no write or pc", rw + pc, 0);
        run_instr("post-reset add", 32'h002081B3, 0, 0, K_ALU, 4'b0000,
                  1'b0, 2'b00, 4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
